// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file.
// Contents: default geometry (DATA_W/ADDR_W) and the reset data constant.
// Optional feature: REG_FILE_BYPASS_EN (write-to-read forwarding), used by
// reg_file_sb_port.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;

  // Single reset bit, replicated to the register width where it is used.
  localparam logic REG_RESET_VAL = 1'b0;

endpackage

// File: rtl/reg_file_sb_port.sv
// One registered read port of reg_file_sb.
// Holds the output data register and the sampled busy bit; both load only
// when read=1 and otherwise hold their last value.
// Ports:
//   clk, reset          clock, async active-low reset
//   read                load enable for this port
//   addr                register index this port reads
//   reg_data, reg_busy  current (pre-edge) contents/busy of reg[addr]
//   write, wr_addr, wr_data, reserve, res_addr
//                       same-cycle writeback/reserve, used only for forwarding
//   data, busy          registered port outputs
// Macro REG_FILE_BYPASS_EN: when defined, a same-cycle write to addr is
// forwarded to data and busy takes the post-edge scoreboard value. When
// undefined, the port returns pre-write contents and pre-edge busy.
module reg_file_sb_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_busy,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic [DATA_W-1:0] next_data;
  logic              next_busy;

`ifdef REG_FILE_BYPASS_EN
  logic wr_hit;
  logic res_hit;

  always_comb begin
    wr_hit    = write && (wr_addr == addr);
    res_hit   = reserve && (res_addr == addr);
    next_data = reg_data;
    next_busy = reg_busy;
    if (wr_hit) begin
      // Writeback clears busy, but a new producer reserving the same index
      // in this cycle wins.
      next_data = wr_data;
      next_busy = res_hit;
    end
  end
`else
  // Forwarding inputs are only consumed in the bypass build.
  logic unused_fwd;
  assign unused_fwd = ^{write, wr_addr, wr_data, reserve, res_addr};

  always_comb begin
    next_data = reg_data;
    next_busy = reg_busy;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= {DATA_W{REG_RESET_VAL}};
      busy <= 1'b0;
    end else if (read) begin
      data <= next_data;
      busy <= next_busy;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register scoreboard (busy bits).
// Issue stage reserves destinations (RESERVE) and reads operands (READ);
// ALU writeback writes results (WRITE), clearing the busy bit.
// Ports:
//   CLK, RESET                     clock, async active-low reset
//   WRITE, INADDRESS, IN           writeback
//   RESERVE, RESADDRESS            mark a register pending
//   READ, OUT1ADDRESS, OUT2ADDRESS read request for both ports
//   OUT1, OUT2, BUSY1, BUSY2       registered read results
//   OUT_VALID                      results were loaded by a READ last cycle
// Read protocol: READ is a one-cycle request with no backpressure; exactly
// one cycle later OUT_VALID=1 marks OUT1/OUT2/BUSY1/BUSY2 as fresh. When
// READ=0 the data outputs hold and OUT_VALID drops. A READ every cycle
// sustains OUT_VALID=1.
// Macro REG_FILE_BYPASS_EN selects same-cycle write forwarding in the ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RESADDRESS,
  input  logic              READ,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              OUT_VALID
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{REG_RESET_VAL}};
      end
    end else if (WRITE) begin
      regs[INADDRESS] <= IN;
    end
  end

  // Reserve is assigned after the writeback clear so that a same-index
  // WRITE+RESERVE leaves the register pending (new producer wins).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy <= '0;
    end else begin
      if (WRITE) begin
        busy[INADDRESS] <= 1'b0;
      end
      if (RESERVE) begin
        busy[RESADDRESS] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= READ;
    end
  end

  reg_file_sb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .clk      (CLK),
    .reset    (RESET),
    .read     (READ),
    .addr     (OUT1ADDRESS),
    .reg_data (regs[OUT1ADDRESS]),
    .reg_busy (busy[OUT1ADDRESS]),
    .write    (WRITE),
    .wr_addr  (INADDRESS),
    .wr_data  (IN),
    .reserve  (RESERVE),
    .res_addr (RESADDRESS),
    .data     (OUT1),
    .busy     (BUSY1)
  );

  reg_file_sb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .clk      (CLK),
    .reset    (RESET),
    .read     (READ),
    .addr     (OUT2ADDRESS),
    .reg_data (regs[OUT2ADDRESS]),
    .reg_busy (busy[OUT2ADDRESS]),
    .write    (WRITE),
    .wr_addr  (INADDRESS),
    .wr_data  (IN),
    .reserve  (RESERVE),
    .res_addr (RESADDRESS),
    .data     (OUT2),
    .busy     (BUSY2)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default 8x8 instance checked against an array-based
// reference model, plus a 16-bit x 16-entry instance for the wide geometry.
module tb_reg_file_sb;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET;
  logic       WRITE, RESERVE, READ;
  logic [2:0] INADDRESS, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] IN;
  logic [7:0] OUT1, OUT2;
  logic       BUSY1, BUSY2, OUT_VALID;

  // wide instance signals
  logic        w_write, w_reserve, w_read;
  logic [3:0]  w_inaddr, w_resaddr, w_a1, w_a2;
  logic [15:0] w_in, w_out1, w_out2;
  logic        w_busy1, w_busy2, w_valid;

  int errors = 0;
  int checks = 0;

  reg_file_sb dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .READ(READ),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .OUT_VALID(OUT_VALID)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4)) dut_wide (
    .CLK(CLK), .RESET(RESET), .WRITE(w_write), .INADDRESS(w_inaddr), .IN(w_in),
    .RESERVE(w_reserve), .RESADDRESS(w_resaddr), .READ(w_read),
    .OUT1ADDRESS(w_a1), .OUT2ADDRESS(w_a2),
    .OUT1(w_out1), .OUT2(w_out2), .BUSY1(w_busy1), .BUSY2(w_busy2),
    .OUT_VALID(w_valid)
  );

  // ---------------- reference model ----------------
  logic [7:0] m_regs [8];
  logic       m_busy [8];
  logic [7:0] e_out1, e_out2;
  logic       e_b1, e_b2, e_valid;
  logic [18:0] exp_q[$];   // {valid, busy1, busy2, out1, out2}

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_busy[i] = 1'b0;
    end
    e_out1 = 8'h00; e_out2 = 8'h00; e_b1 = 1'b0; e_b2 = 1'b0; e_valid = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, waits for the edge, advances the model and
  // returns 1 time unit after the edge.
  task automatic drive_cycle(input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                             input logic rs, input logic [2:0] ra,
                             input logic rd, input logic [2:0] a1, input logic [2:0] a2);
    WRITE = wr; INADDRESS = wa; IN = wd;
    RESERVE = rs; RESADDRESS = ra;
    READ = rd; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    @(posedge CLK);
    if (rd) begin
      e_out1 = m_regs[a1]; e_b1 = m_busy[a1];
      e_out2 = m_regs[a2]; e_b2 = m_busy[a2];
`ifdef REG_FILE_BYPASS_EN
      if (wr && wa == a1) begin e_out1 = wd; e_b1 = rs && (ra == a1); end
      if (wr && wa == a2) begin e_out2 = wd; e_b2 = rs && (ra == a2); end
`endif
    end
    e_valid = rd;
    if (wr) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
    if (rs) m_busy[ra] = 1'b1;
    exp_q.push_back({e_valid, e_b1, e_b2, e_out1, e_out2});
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic read_pair(input logic [2:0] a1, input logic [2:0] a2);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, a1, a2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0;
    model_reset();
    w_write = 0; w_reserve = 0; w_read = 0; w_inaddr = 0; w_resaddr = 0;
    w_a1 = 0; w_a2 = 0; w_in = 0;
    for (int i = 0; i < 4; i++) begin
      WRITE = 1'($urandom); INADDRESS = 3'($urandom); IN = 8'($urandom);
      RESERVE = 1'($urandom); RESADDRESS = 3'($urandom);
      READ = 1'($urandom); OUT1ADDRESS = 3'($urandom); OUT2ADDRESS = 3'($urandom);
      @(posedge CLK); #1;
      checks++;
      if ({OUT1, OUT2, BUSY1, BUSY2, OUT_VALID} !== 19'd0) begin
        errors++;
        $display("FAIL reset_hold: out1=%h out2=%h b1=%b b2=%b v=%b required all 0",
                 OUT1, OUT2, BUSY1, BUSY2, OUT_VALID);
      end
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int r = 0; r < 8; r++) begin
      read_pair(3'(r), 3'(7 - r));
      checks++;
      if (OUT1 !== 8'h00 || OUT2 !== 8'h00 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0 ||
          OUT_VALID !== 1'b1) begin
        errors++;
        $display("FAIL reset_read r%0d: out1=%h out2=%h b1=%b b2=%b v=%b required 00 00 0 0 1",
                 r, OUT1, OUT2, BUSY1, BUSY2, OUT_VALID);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL wr_novalid: valid=%b required 0", OUT_VALID);
    end
    read_pair(3'd3, 3'd3);
    checks++;
    if (OUT1 !== 8'hA5 || OUT2 !== 8'hA5 || OUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL wr_read: out1=%h out2=%h v=%b required a5 a5 1", OUT1, OUT2, OUT_VALID);
    end
    idle();
    checks++;
    if (OUT_VALID !== 1'b0 || OUT1 !== 8'hA5) begin
      errors++;
      $display("FAIL read_drop: v=%b out1=%h required v=0 out1 held a5", OUT_VALID, OUT1);
    end
  endtask

  task automatic test_scoreboard();
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0, 3'd0);
    read_pair(3'd5, 3'd4);
    checks++;
    if (BUSY1 !== 1'b1 || BUSY2 !== 1'b0) begin
      errors++; $display("FAIL sb_reserved: b1=%b b2=%b required 1 0", BUSY1, BUSY2);
    end
    // reserve again on a busy register: stays busy
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd5, 3'd5);
    checks++;
    if (BUSY1 !== 1'b1 || BUSY2 !== 1'b1) begin
      errors++; $display("FAIL sb_rereserve: b1=%b b2=%b required 1 1", BUSY1, BUSY2);
    end
    drive_cycle(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    read_pair(3'd5, 3'd5);
    checks++;
    if (OUT1 !== 8'h3C || BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
      errors++; $display("FAIL sb_written: out1=%h b1=%b b2=%b required 3c 0 0", OUT1, BUSY1, BUSY2);
    end
  endtask

  task automatic test_collision();
    logic [7:0] want;
`ifdef REG_FILE_BYPASS_EN
    want = 8'h22;
`else
    want = 8'h11;
`endif
    drive_cycle(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    drive_cycle(1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 1'b1, 3'd2, 3'd2);
    checks++;
    if (OUT1 !== want || OUT2 !== want) begin
      errors++; $display("FAIL collision: out1=%h out2=%h required %h", OUT1, OUT2, want);
    end
    read_pair(3'd2, 3'd1);
    checks++;
    if (OUT1 !== 8'h22) begin
      errors++; $display("FAIL collision_next: out1=%h required 22", OUT1);
    end
  endtask

  task automatic test_write_reserve();
    drive_cycle(1'b1, 3'd6, 8'h5A, 1'b1, 3'd6, 1'b0, 3'd0, 3'd0);
    read_pair(3'd6, 3'd6);
    checks++;
    if (OUT1 !== 8'h5A || BUSY1 !== 1'b1 || BUSY2 !== 1'b1) begin
      errors++; $display("FAIL wr_res: out1=%h b1=%b b2=%b required 5a 1 1", OUT1, BUSY1, BUSY2);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0);
    drive_cycle(1'b1, 3'd1, 8'hFF, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0);
    read_pair(3'd1, 3'd1);   // OUT1=FF, BUSY=1, valid=1
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({OUT1, OUT2, BUSY1, BUSY2, OUT_VALID} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: out1=%h out2=%h b1=%b b2=%b v=%b required all 0",
               OUT1, OUT2, BUSY1, BUSY2, OUT_VALID);
    end
    @(negedge CLK);
    RESET = 1'b1;
    read_pair(3'd1, 3'd1);
    checks++;
    if (OUT1 !== 8'h00 || BUSY1 !== 1'b0 || OUT_VALID !== 1'b1) begin
      errors++; $display("FAIL post_reset_read: out1=%h b1=%b v=%b required 00 0 1", OUT1, BUSY1, OUT_VALID);
    end
  endtask

  task automatic test_random();
    logic [18:0] exp_v;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      drive_cycle(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom));
      exp_v = exp_q.pop_front();
      checks++;
      if ({OUT_VALID, BUSY1, BUSY2, OUT1, OUT2} !== exp_v) begin
        errors++;
        $display("FAIL random n%0d: got v=%b b=%b%b o=%h/%h required v=%b b=%b%b o=%h/%h",
                 n, OUT_VALID, BUSY1, BUSY2, OUT1, OUT2,
                 exp_v[18], exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
      end
    end
    idle();
  endtask

  task automatic test_wide();
    w_write = 1; w_inaddr = 4'd15; w_in = 16'hBEEF;
    @(posedge CLK); #1;
    w_write = 1; w_inaddr = 4'd8; w_in = 16'h1234;
    w_reserve = 1; w_resaddr = 4'd8;
    @(posedge CLK); #1;
    w_write = 0; w_reserve = 0; w_read = 1; w_a1 = 4'd15; w_a2 = 4'd8;
    @(posedge CLK); #1;
    w_read = 0;
    checks++;
    if (w_out1 !== 16'hBEEF || w_out2 !== 16'h1234 || w_busy1 !== 1'b0 ||
        w_busy2 !== 1'b1 || w_valid !== 1'b1) begin
      errors++;
      $display("FAIL wide: out1=%h out2=%h b1=%b b2=%b v=%b required beef 1234 0 1 1",
               w_out1, w_out2, w_busy1, w_busy2, w_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_write_reserve();
    test_async_reset();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 8x8 register file. Adds configurable width/depth, a synchronous registered read port pair with valid flag, and a per-register scoreboard (busy bits) that tracks pending writebacks for the CPU issue logic. Sits between the decoder/issue stage (RESERVE, reads) and the ALU writeback (WRITE).

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W registers

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
WRITE  in  1  writeback enable
INADDRESS  in  ADDR_W  writeback register index
IN  in  DATA_W  writeback data
RESERVE  in  1  mark destination register pending
RESADDRESS  in  ADDR_W  register index to reserve
READ  in  1  read request, both ports
OUT1ADDRESS  in  ADDR_W  read port 1 index
OUT2ADDRESS  in  ADDR_W  read port 2 index
OUT1  out  DATA_W  read port 1 data (registered)
OUT2  out  DATA_W  read port 2 data (registered)
BUSY1  out  1  port 1 register pending at sample time
BUSY2  out  1  port 2 register pending at sample time
OUT_VALID  out  1  OUT1/OUT2/BUSY1/BUSY2 updated by a READ last cycle

Behaviour:
- RESET=0 (async, immediate): all registers = 0, all busy bits = 0, OUT1 = OUT2 = 0, BUSY1 = BUSY2 = 0, OUT_VALID = 0. Held while RESET=0; operation resumes at first rising edge after RESET=1.
- Reset mid-operation discards pending reservations and any in-flight read result. No write occurs on the deasserting edge unless RESET=1 at that edge.
- Write: WRITE=1 at edge -> reg[INADDRESS] <= IN; busy[INADDRESS] <= 0.
- Reserve: RESERVE=1 at edge -> busy[RESADDRESS] <= 1.
- WRITE and RESERVE to the same index in the same cycle: data written, busy ends 1 (new producer wins).
- RESERVE on an already-busy register: stays 1. No error.
- WRITE to a non-busy register: allowed, data written, busy stays 0.
- Read: READ=1 at edge -> OUT1/OUT2 <= reg[addr], BUSY1/BUSY2 <= busy[addr], OUT_VALID <= 1. Latency is 1 cycle.
- READ=0 at edge -> OUT1/OUT2/BUSY1/BUSY2 hold; OUT_VALID <= 0.
- Both ports may address the same register; both return identical data.
- Read of a register written in the same cycle: see Optional Feature.
- Back-to-back READ every cycle: OUT_VALID stays 1, throughput 1 read pair per cycle.
- Fully synthesizable: nonblocking assignments, no # delays.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: a same-cycle WRITE with INADDRESS == OUTnADDRESS forwards IN to OUTn, and BUSYn takes the post-edge busy value (0, or 1 if RESERVE hits the same index).
- Undefined: OUTn returns the pre-write register contents and BUSYn the pre-edge busy bit. The written value is visible from the next READ onward.

Decomposition:
- Package reg_file_pkg: default DATA_W/ADDR_W localparams, reset data constant REG_RESET_VAL = 0.
- Sub-module reg_file_sb_port: one read port. Contains the output register, busy sample, and bypass mux. Instantiated twice; OUT_VALID is generated once at top level.

Test Plan:
- Reset: hold RESET=0 with random inputs, toggling CLK -> all outputs 0, OUT_VALID=0. Release, READ regs 0..7 -> all 0, BUSY=0.
- Write/read: WRITE reg3=8'hA5, next cycle READ OUT1ADDRESS=3, OUT2ADDRESS=3 -> one cycle later OUT1=OUT2=8'hA5, OUT_VALID=1, then 0 after READ drops.
- Scoreboard: RESERVE reg5, READ 5 -> BUSY1=1. WRITE reg5=8'h3C, READ 5 -> OUT1=8'h3C, BUSY1=0.
- Same-cycle collision: reg2=8'h11, then WRITE reg2=8'h22 plus READ 2 in the same cycle. With REG_FILE_BYPASS_EN: OUT1=8'h22. Without: OUT1=8'h11, and the following READ gives 8'h22.
- WRITE and RESERVE reg6 in the same cycle -> data updated, BUSY=1 on next read.
- Async reset mid-run: RESERVE reg1, write reg1=8'hFF, assert RESET=0 between edges -> outputs 0 immediately, subsequent READ 1 returns 0 with BUSY1=0.
- Parameter sweep: DATA_W=16, ADDR_W=4 -> write/read reg15=16'hBEEF returns 16'hBEEF.
